leaf_run_feeder: RTL and testbench
==================================

Name: leaf_run_feeder

Overview:
- Producer side of the merger-tree leaf interface.
- Holds LEAF_CNT sorted runs in one shared synchronous RAM. Run i occupies addresses i*LEN_SEQ .. i*LEN_SEQ+LEN_SEQ-1.
- Streams each run into its own leaf FIFO, then appends TERM_CNT zero terminator words.
- One memory read port is shared across all leaves by round-robin arbitration. Per-leaf backpressure comes from the FIFO full flags.

Parameters:
- LEAF_CNT, 16, number of leaf FIFOs/runs
- DATA_WIDTH, 32, word width
- LEN_SEQ, 128, words per run
- TERM_CNT, 20, zero terminators written after each run
- ADDR_WIDTH, 12, RAM address width; must satisfy 2^ADDR_WIDTH >= LEAF_CNT*LEN_SEQ

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_start  in  1  one-cycle pulse that begins a load
- o_mem_addr  out  ADDR_WIDTH  RAM read address
- o_mem_read  out  1  RAM read enable
- i_mem_data  in  DATA_WIDTH  RAM data, valid on the cycle after o_mem_read
- i_fifo_full  in  LEAF_CNT  per-leaf FIFO full flag
- o_fifo_write  out  LEAF_CNT  per-leaf write strobe
- o_fifo_item  out  LEAF_CNT*DATA_WIDTH  per-leaf write data; leaf i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- o_busy  out  1  load in progress
- o_done  out  1  level; all leaves finished since the last start

Behaviour:
- Reset values:
  - all outputs 0.
  - all leaves in IDLE.
  - arbiter pointer 0.
  - in-flight flags and hold registers cleared.
  - A reset mid-run discards any pending RAM data; no FIFO write occurs after reset asserts.
- All outputs are registered.
- i_start:
  - accepted only when o_busy=0.
  - on accept: every leaf goes IDLE->DATA with idx=0 and term=0; o_busy<=1; o_done<=0.
  - i_start while busy is ignored.
- Per-leaf state machine:
  - IDLE.
  - DATA: idx counts 0..LEN_SEQ.
  - TERM: term counts 0..TERM_CNT.
  - DONE.
- Leaf i is eligible for a RAM grant when all hold: state DATA, idx<LEN_SEQ, no read in flight, hold register empty, i_fifo_full[i]=0.
- Arbiter:
  - at most one grant per cycle.
  - grants the lowest eligible index at or above the pointer, wrapping.
  - after granting g, pointer <= (g+1) mod LEAF_CNT.
  - no grant leaves the pointer unchanged.
- Grant at cycle t:
  - o_mem_read=1 and o_mem_addr=i*LEN_SEQ+idx, both registered at edge t.
  - idx++.
  - in-flight[i] set.
- Data return:
  - the word arrives at t+1.
  - if i_fifo_full[i]=0 at that edge: o_fifo_write[i]=1 with that word on the next cycle.
  - otherwise the word goes to hold[i] and is written on the first cycle full=0.
  - no word is ever dropped or duplicated.
- Once idx=LEN_SEQ and no word is in flight or held, the leaf enters TERM.
  - TERM: one zero write per cycle while full=0, term++.
  - at term=TERM_CNT: DONE.
- Terminator writes bypass the RAM. Different leaves may write in the same cycle.
- A leaf never writes when its full flag was sampled high on the deciding edge. The FIFO must assert full within one cycle of the write that fills it.
- When all leaves are DONE: o_busy<=0 and o_done<=1, both in the same cycle.

Test Plan:
- Nominal ordering. Config: LEAF_CNT=4, LEN_SEQ=8, TERM_CNT=3, mem[a]=a+1, full=0.
  - RAM addresses issued in order 0,8,16,24,1,9,17,25,...
  - leaf i receives i*8+1..i*8+8 then 3 zeros; 44 writes total.
  - o_done=1 and o_busy=0 after the last write.
- Stall: hold i_fifo_full[2]=1 for 20 cycles mid-run.
  - no reads for leaf 2 while held; leaves 0, 1 and 3 progress.
  - leaf 2 resumes at the next address with no gap or duplicate.
- Hold path: raise i_fifo_full[1] on the cycle its read data returns, release 5 cycles later.
  - exactly one write of that word, at the release cycle.
- Mid-run reset: assert i_rst at write 20.
  - all outputs 0 asynchronously.
  - new i_start restarts every leaf from address i*8.
- Start while busy: pulse i_start during a run.
  - no restart; addresses and counts match the nominal scenario.
- Completion: after o_done=1, pulse i_start.
  - o_done clears next cycle and a full second pass matches the nominal scenario.

Source files
------------

// File: rtl/leaf_run_feeder.sv
// leaf_run_feeder: streams LEAF_CNT sorted runs from one shared synchronous
// RAM into per-leaf FIFOs, then appends TERM_CNT zero terminators per leaf.
// A single RAM read port is shared round-robin.
// Each leaf keeps at most one word in flight.
// A one-word hold register absorbs data that returns while the leaf FIFO is full.
module leaf_run_feeder #(
  parameter int LEAF_CNT   = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_SEQ    = 128,
  parameter int TERM_CNT   = 20,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_start,
  output logic [ADDR_WIDTH-1:0]          o_mem_addr,
  output logic                           o_mem_read,
  input  logic [DATA_WIDTH-1:0]          i_mem_data,
  input  logic [LEAF_CNT-1:0]            i_fifo_full,
  output logic [LEAF_CNT-1:0]            o_fifo_write,
  output logic [LEAF_CNT*DATA_WIDTH-1:0] o_fifo_item,
  output logic                           o_busy,
  output logic                           o_done
);

  localparam int PTR_W  = (LEAF_CNT > 1) ? $clog2(LEAF_CNT) : 1;
  localparam int IDX_W  = $clog2(LEN_SEQ + 1);
  localparam int TERM_W = (TERM_CNT > 0) ? $clog2(TERM_CNT + 1) : 1;

  typedef enum logic [1:0] {IDLE, DATA, TERM, DONE} leaf_state_t;

  logic [PTR_W-1:0]      ptr_reg, ptr_next;
  logic                  busy_reg, done_reg;
  logic                  mem_read_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [PTR_W-1:0]      rd_leaf_reg;
  logic                  ret_valid_reg;
  logic [PTR_W-1:0]      ret_leaf_reg;
  logic                  start_accept;

  logic [LEAF_CNT-1:0]   eligible, grant, ret_hit, leaf_done;
  logic [IDX_W-1:0]      leaf_idx [LEAF_CNT];
  logic                  grant_valid;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      cand;

  assign start_accept = i_start && !busy_reg;

  // Round-robin pick: first eligible leaf at or above the pointer, wrapping.
  always_comb begin
    grant         = '0;
    grant_valid   = 1'b0;
    grant_idx     = '0;
    cand          = '0;
    ptr_next      = ptr_reg;
    mem_addr_next = mem_addr_reg;
    for (int k = 0; k < LEAF_CNT; k++) begin
      cand = PTR_W'((int'(ptr_reg) + k) % LEAF_CNT);
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (grant_valid) begin
      grant[grant_idx] = 1'b1;
      ptr_next = (grant_idx == PTR_W'(LEAF_CNT - 1)) ? '0 : grant_idx + PTR_W'(1);
      mem_addr_next = ADDR_WIDTH'(int'(grant_idx) * LEN_SEQ + int'(leaf_idx[grant_idx]));
    end
  end

  // Shared read port, return pipeline (RAM data is valid one cycle after the
  // registered read), and the load-level busy/done flags.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_addr_reg  <= '0;
      rd_leaf_reg   <= '0;
      ret_valid_reg <= 1'b0;
      ret_leaf_reg  <= '0;
    end else begin
      // every load begins arbitration from leaf 0
      ptr_reg       <= start_accept ? '0 : ptr_next;
      mem_read_reg  <= grant_valid;
      if (grant_valid) begin
        mem_addr_reg <= mem_addr_next;
        rd_leaf_reg  <= grant_idx;
      end
      ret_valid_reg <= mem_read_reg;
      ret_leaf_reg  <= rd_leaf_reg;
      if (start_accept) begin
        busy_reg <= 1'b1;
        done_reg <= 1'b0;
      end else if (busy_reg && (&leaf_done)) begin
        busy_reg <= 1'b0;
        done_reg <= 1'b1;
      end
    end
  end

  assign o_mem_read = mem_read_reg;
  assign o_mem_addr = mem_addr_reg;
  assign o_busy     = busy_reg;
  assign o_done     = done_reg;

  for (genvar gi = 0; gi < LEAF_CNT; gi++) begin : g_leaf
    leaf_state_t           state_reg, state_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic [TERM_W-1:0]     term_reg, term_next;
    logic                  inflight_reg, inflight_next;
    logic                  hold_valid_reg, hold_valid_next;
    logic [DATA_WIDTH-1:0] hold_data_reg, hold_data_next;
    logic [DATA_WIDTH-1:0] item_reg, item_next;
    logic                  write_reg, write_next;

    assign eligible[gi]  = (state_reg == DATA) && (idx_reg < IDX_W'(LEN_SEQ)) &&
                           !inflight_reg && !hold_valid_reg && !i_fifo_full[gi];
    assign ret_hit[gi]   = ret_valid_reg && (ret_leaf_reg == PTR_W'(gi));
    assign leaf_done[gi] = (state_reg == DONE);
    assign leaf_idx[gi]  = idx_reg;
    assign o_fifo_write[gi] = write_reg;
    assign o_fifo_item[gi*DATA_WIDTH +: DATA_WIDTH] = item_reg;

    // Leaf sequencing: issue reads, route returned words to the FIFO or the
    // hold register, then emit terminators while the FIFO has room.
    always_comb begin
      state_next      = state_reg;
      idx_next        = idx_reg;
      term_next       = term_reg;
      inflight_next   = inflight_reg;
      hold_valid_next = hold_valid_reg;
      hold_data_next  = hold_data_reg;
      item_next       = item_reg;
      write_next      = 1'b0;
      if (start_accept) begin
        state_next      = DATA;
        idx_next        = '0;
        term_next       = '0;
        inflight_next   = 1'b0;
        hold_valid_next = 1'b0;
      end else begin
        case (state_reg)
          DATA: begin
            if (hold_valid_reg) begin
              if (!i_fifo_full[gi]) begin
                write_next      = 1'b1;
                item_next       = hold_data_reg;
                hold_valid_next = 1'b0;
              end
            end else if (ret_hit[gi]) begin
              inflight_next = 1'b0;
              if (!i_fifo_full[gi]) begin
                write_next = 1'b1;
                item_next  = i_mem_data;
              end else begin
                hold_valid_next = 1'b1;
                hold_data_next  = i_mem_data;
              end
            end
            if (grant[gi]) begin
              idx_next      = idx_reg + IDX_W'(1);
              inflight_next = 1'b1;
            end
            // the run is drained once every word has left the leaf
            if ((idx_reg == IDX_W'(LEN_SEQ)) && !inflight_reg && !hold_valid_reg)
              state_next = TERM;
          end
          TERM: begin
            if (term_reg == TERM_W'(TERM_CNT)) begin
              state_next = DONE;
            end else if (!i_fifo_full[gi]) begin
              write_next = 1'b1;
              item_next  = '0;
              term_next  = term_reg + TERM_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end

    // Leaf state register; reset drops any word in flight or held.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state_reg      <= IDLE;
        idx_reg        <= '0;
        term_reg       <= '0;
        inflight_reg   <= 1'b0;
        hold_valid_reg <= 1'b0;
        hold_data_reg  <= '0;
        item_reg       <= '0;
        write_reg      <= 1'b0;
      end else begin
        state_reg      <= state_next;
        idx_reg        <= idx_next;
        term_reg       <= term_next;
        inflight_reg   <= inflight_next;
        hold_valid_reg <= hold_valid_next;
        hold_data_reg  <= hold_data_next;
        item_reg       <= item_next;
        write_reg      <= write_next;
      end
    end
  end

endmodule

// File: tb/tb_leaf_run_feeder.sv
// Testbench for leaf_run_feeder: small configuration (4 leaves, 8-word runs,
// 3 terminators), behavioural RAM, event recorder and per-scenario tasks.
module tb_leaf_run_feeder;
  localparam int L  = 4;
  localparam int DW = 32;
  localparam int LS = 8;
  localparam int TC = 3;
  localparam int AW = 6;
  localparam int NW = LS + TC;

  logic          clk, rst, start;
  logic [AW-1:0] mem_addr;
  logic          mem_read;
  logic [DW-1:0] mem_data, mem_q;
  logic [L-1:0]  fifo_full, fifo_write, full_at_edge;
  logic [L*DW-1:0] fifo_item;
  logic          busy, done;

  leaf_run_feeder #(.LEAF_CNT(L), .DATA_WIDTH(DW), .LEN_SEQ(LS), .TERM_CNT(TC), .ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .o_mem_addr(mem_addr), .o_mem_read(mem_read), .i_mem_data(mem_data),
    .i_fifo_full(fifo_full), .o_fifo_write(fifo_write), .o_fifo_item(fifo_item),
    .o_busy(busy), .o_done(done)
  );

  int vec = 0;
  int miss = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural synchronous RAM: data valid the cycle after the read
  logic [DW-1:0] mem [0:63];
  always @(posedge clk) if (mem_read) mem_q <= mem[mem_addr];
  assign mem_data = mem_q;

  // recorder: logs reads and per-leaf writes; a new gen value clears the logs
  int gen = 0, seen_gen = 0;
  logic [AW-1:0] addr_log [0:511];
  int addr_cnt = 0, total_wr = 0, wr_viol = 0, rd_viol = 0;
  int rd_cnt [L];
  int obs_cnt [L];
  logic [DW-1:0] obs [L][0:63];

  always @(posedge clk) full_at_edge <= fifo_full;

  always @(negedge clk) begin
    if (gen != seen_gen) begin
      seen_gen = gen; addr_cnt = 0; total_wr = 0; wr_viol = 0; rd_viol = 0;
      for (int i = 0; i < L; i++) begin rd_cnt[i] = 0; obs_cnt[i] = 0; end
    end
    if (mem_read) begin
      int lf;
      lf = int'(mem_addr) / LS;
      if (addr_cnt < 512) addr_log[addr_cnt] = mem_addr;
      addr_cnt++;
      if (lf >= L) rd_viol++;
      else begin
        rd_cnt[lf]++;
        if (full_at_edge[lf]) rd_viol++;
      end
    end
    for (int i = 0; i < L; i++) begin
      if (fifo_write[i]) begin
        if (obs_cnt[i] < 64) obs[i][obs_cnt[i]] = fifo_item[i*DW +: DW];
        obs_cnt[i]++;
        total_wr++;
        if (full_at_edge[i]) wr_viol++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    gen++;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; fifo_full = '0;
    repeat (3) step();
    vec++; if (mem_read !== 1'b0) begin miss++; $display("FAIL reset mem_read: got %b want 0", mem_read); end
    vec++; if (mem_addr !== '0) begin miss++; $display("FAIL reset mem_addr: got %0d want 0", mem_addr); end
    vec++; if (fifo_write !== '0) begin miss++; $display("FAIL reset fifo_write: got %b want 0", fifo_write); end
    vec++; if (fifo_item !== '0) begin miss++; $display("FAIL reset fifo_item: got %h want 0", fifo_item); end
    vec++; if (busy !== 1'b0 || done !== 1'b0) begin miss++; $display("FAIL reset busy/done: got %b/%b want 0/0", busy, done); end
    rst = 1'b0;
    repeat (2) step();
    vec++; if (busy !== 1'b0 || mem_read !== 1'b0) begin miss++; $display("FAIL idle after reset: busy=%b read=%b want 0/0", busy, mem_read); end
    $display("test_reset done");
  endtask

  task automatic test_nominal();
    for (int a = 0; a < 64; a++) mem[a] = DW'(a + 1);
    fifo_full = '0;
    pulse_start();
    for (int c = 0; c < 2000 && !done; c++) step();
    vec++; if (done !== 1'b1) begin miss++; $display("FAIL nominal done: got %b want 1", done); end
    vec++; if (addr_cnt !== L*LS) begin miss++; $display("FAIL nominal reads: got %0d want %0d", addr_cnt, L*LS); end
    for (int n = 0; n < L*LS && n < addr_cnt; n++) begin
      vec++; if (int'(addr_log[n]) !== (n % L) * LS + n / L) begin miss++; $display("FAIL nominal addr[%0d]: got %0d want %0d", n, addr_log[n], (n % L) * LS + n / L); end
    end
    for (int i = 0; i < L; i++) begin
      vec++; if (obs_cnt[i] !== NW) begin miss++; $display("FAIL nominal leaf%0d count: got %0d want %0d", i, obs_cnt[i], NW); end
      for (int k = 0; k < NW && k < obs_cnt[i]; k++) begin
        vec++; if (obs[i][k] !== ((k < LS) ? mem[i*LS+k] : {DW{1'b0}})) begin miss++; $display("FAIL nominal leaf%0d word%0d: got %h want %h", i, k, obs[i][k], (k < LS) ? mem[i*LS+k] : {DW{1'b0}}); end
      end
    end
    vec++; if (total_wr !== L*NW || busy !== 1'b0) begin miss++; $display("FAIL nominal end: writes=%0d busy=%b want %0d/0", total_wr, busy, L*NW); end
    $display("test_nominal: %0d reads, %0d writes", addr_cnt, total_wr);
  endtask

  task automatic test_completion();
    pulse_start();
    vec++; if (done !== 1'b0 || busy !== 1'b1) begin miss++; $display("FAIL restart flags: done=%b busy=%b want 0/1", done, busy); end
    for (int c = 0; c < 2000 && !done; c++) step();
    vec++; if (done !== 1'b1) begin miss++; $display("FAIL second pass done: got %b want 1", done); end
    vec++; if (addr_cnt !== L*LS) begin miss++; $display("FAIL second pass reads: got %0d want %0d", addr_cnt, L*LS); end
    for (int n = 0; n < L*LS && n < addr_cnt; n++) begin
      vec++; if (int'(addr_log[n]) !== (n % L) * LS + n / L) begin miss++; $display("FAIL second pass addr[%0d]: got %0d want %0d", n, addr_log[n], (n % L) * LS + n / L); end
    end
    for (int i = 0; i < L; i++) begin
      vec++; if (obs_cnt[i] !== NW) begin miss++; $display("FAIL second pass leaf%0d count: got %0d want %0d", i, obs_cnt[i], NW); end
      for (int k = 0; k < NW && k < obs_cnt[i]; k++) begin
        vec++; if (obs[i][k] !== ((k < LS) ? mem[i*LS+k] : {DW{1'b0}})) begin miss++; $display("FAIL second pass leaf%0d word%0d: got %h", i, k, obs[i][k]); end
      end
    end
    vec++; if (busy !== 1'b0) begin miss++; $display("FAIL second pass busy: got %b want 0", busy); end
    $display("test_completion: %0d writes", total_wr);
  endtask

  task automatic test_start_while_busy();
    pulse_start();
    repeat (10) step();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) step();
    vec++; if (done !== 1'b1) begin miss++; $display("FAIL busy start done: got %b want 1", done); end
    vec++; if (addr_cnt !== L*LS) begin miss++; $display("FAIL busy start reads: got %0d want %0d", addr_cnt, L*LS); end
    for (int n = 0; n < L*LS && n < addr_cnt; n++) begin
      vec++; if (int'(addr_log[n]) !== (n % L) * LS + n / L) begin miss++; $display("FAIL busy start addr[%0d]: got %0d want %0d", n, addr_log[n], (n % L) * LS + n / L); end
    end
    for (int i = 0; i < L; i++) begin
      vec++; if (obs_cnt[i] !== NW) begin miss++; $display("FAIL busy start leaf%0d count: got %0d want %0d", i, obs_cnt[i], NW); end
    end
    $display("test_start_while_busy: %0d writes", total_wr);
  endtask

  task automatic test_stall();
    int snap [L];
    pulse_start();
    repeat (6) step();
    for (int i = 0; i < L; i++) snap[i] = rd_cnt[i];
    fifo_full[2] = 1'b1;
    repeat (20) step();
    for (int i = 0; i < L; i++) begin
      vec++;
      if (i == 2 ? (rd_cnt[i] !== snap[i]) : (rd_cnt[i] <= snap[i])) begin
        miss++; $display("FAIL stall leaf%0d reads in window: got %0d (before %0d)", i, rd_cnt[i], snap[i]);
      end
    end
    fifo_full[2] = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) step();
    vec++; if (done !== 1'b1) begin miss++; $display("FAIL stall done: got %b want 1", done); end
    begin
      int seen [L];
      for (int i = 0; i < L; i++) seen[i] = 0;
      for (int n = 0; n < addr_cnt && n < 512; n++) begin
        int lf;
        lf = int'(addr_log[n]) / LS;
        vec++;
        if (lf >= L || int'(addr_log[n]) !== lf*LS + seen[lf]) begin miss++; $display("FAIL stall addr[%0d]: got %0d", n, addr_log[n]); end
        if (lf < L) seen[lf]++;
      end
    end
    for (int i = 0; i < L; i++) begin
      vec++; if (obs_cnt[i] !== NW) begin miss++; $display("FAIL stall leaf%0d count: got %0d want %0d", i, obs_cnt[i], NW); end
      for (int k = 0; k < NW && k < obs_cnt[i]; k++) begin
        vec++; if (obs[i][k] !== ((k < LS) ? mem[i*LS+k] : {DW{1'b0}})) begin miss++; $display("FAIL stall leaf%0d word%0d: got %h", i, k, obs[i][k]); end
      end
    end
    vec++; if (rd_viol !== 0 || wr_viol !== 0) begin miss++; $display("FAIL stall full-flag respect: rd=%0d wr=%0d want 0/0", rd_viol, wr_viol); end
    $display("test_stall: %0d reads", addr_cnt);
  endtask

  task automatic test_hold();
    bit found;
    found = 1'b0;
    pulse_start();
    for (int c = 0; c < 200 && !found; c++) begin
      step();
      if (mem_read && mem_addr == AW'(10)) found = 1'b1;
    end
    vec++; if (!found) begin miss++; $display("FAIL hold read of addr 10: got none want 1"); end
    if (found) begin
      step();
      fifo_full[1] = 1'b1;
      for (int c = 0; c < 5; c++) begin
        step();
        vec++; if (fifo_write[1] !== 1'b0) begin miss++; $display("FAIL hold write while full cycle %0d: got %b want 0", c, fifo_write[1]); end
      end
      fifo_full[1] = 1'b0;
      step();
      vec++; if (fifo_write[1] !== 1'b1 || fifo_item[DW +: DW] !== mem[10]) begin miss++; $display("FAIL hold release write: got %b/%h want 1/%h", fifo_write[1], fifo_item[DW +: DW], mem[10]); end
      step();
      vec++; if (fifo_write[1] !== 1'b0) begin miss++; $display("FAIL hold duplicate: got %b want 0", fifo_write[1]); end
    end
    for (int c = 0; c < 2000 && !done; c++) step();
    vec++; if (done !== 1'b1) begin miss++; $display("FAIL hold done: got %b want 1", done); end
    vec++; if (obs_cnt[1] !== NW) begin miss++; $display("FAIL hold leaf1 count: got %0d want %0d", obs_cnt[1], NW); end
    for (int k = 0; k < NW && k < obs_cnt[1]; k++) begin
      vec++; if (obs[1][k] !== ((k < LS) ? mem[LS+k] : {DW{1'b0}})) begin miss++; $display("FAIL hold leaf1 word%0d: got %h", k, obs[1][k]); end
    end
    vec++; if (wr_viol !== 0) begin miss++; $display("FAIL hold write while full: got %0d want 0", wr_viol); end
    $display("test_hold: %0d writes", total_wr);
  endtask

  task automatic test_mid_reset();
    pulse_start();
    for (int c = 0; c < 500 && total_wr < 20; c++) step();
    vec++; if (total_wr < 20) begin miss++; $display("FAIL mid reset reach 20 writes: got %0d", total_wr); end
    rst = 1'b1;
    #1;
    vec++; if (fifo_write !== '0 || fifo_item !== '0) begin miss++; $display("FAIL async reset fifo: got %b/%h want 0/0", fifo_write, fifo_item); end
    vec++; if (mem_read !== 1'b0 || mem_addr !== '0) begin miss++; $display("FAIL async reset mem: got %b/%0d want 0/0", mem_read, mem_addr); end
    vec++; if (busy !== 1'b0 || done !== 1'b0) begin miss++; $display("FAIL async reset flags: got %b/%b want 0/0", busy, done); end
    for (int c = 0; c < 3; c++) begin
      step();
      vec++; if (fifo_write !== '0) begin miss++; $display("FAIL write during reset: got %b want 0", fifo_write); end
    end
    rst = 1'b0;
    step();
    pulse_start();
    for (int c = 0; c < 2000 && !done; c++) step();
    vec++; if (done !== 1'b1) begin miss++; $display("FAIL post reset done: got %b want 1", done); end
    vec++; if (addr_cnt !== L*LS) begin miss++; $display("FAIL post reset reads: got %0d want %0d", addr_cnt, L*LS); end
    for (int n = 0; n < L*LS && n < addr_cnt; n++) begin
      vec++; if (int'(addr_log[n]) !== (n % L) * LS + n / L) begin miss++; $display("FAIL post reset addr[%0d]: got %0d want %0d", n, addr_log[n], (n % L) * LS + n / L); end
    end
    for (int i = 0; i < L; i++) begin
      vec++; if (obs_cnt[i] !== NW) begin miss++; $display("FAIL post reset leaf%0d count: got %0d want %0d", i, obs_cnt[i], NW); end
      for (int k = 0; k < NW && k < obs_cnt[i]; k++) begin
        vec++; if (obs[i][k] !== ((k < LS) ? mem[i*LS+k] : {DW{1'b0}})) begin miss++; $display("FAIL post reset leaf%0d word%0d: got %h", i, k, obs[i][k]); end
      end
    end
    $display("test_mid_reset: %0d writes after restart", total_wr);
  endtask

  task automatic test_random();
    for (int pass = 0; pass < 3; pass++) begin
      for (int a = 0; a < 64; a++) mem[a] = $urandom;
      pulse_start();
      for (int c = 0; c < 3000 && !done; c++) begin
        step();
        for (int i = 0; i < L; i++) fifo_full[i] = ($urandom_range(0, 99) < 40);
      end
      fifo_full = '0;
      vec++; if (done !== 1'b1) begin miss++; $display("FAIL random pass%0d done: got %b want 1", pass, done); end
      vec++; if (addr_cnt !== L*LS) begin miss++; $display("FAIL random pass%0d reads: got %0d want %0d", pass, addr_cnt, L*LS); end
      begin
        int seen [L];
        for (int i = 0; i < L; i++) seen[i] = 0;
        for (int n = 0; n < addr_cnt && n < 512; n++) begin
          int lf;
          lf = int'(addr_log[n]) / LS;
          vec++;
          if (lf >= L || int'(addr_log[n]) !== lf*LS + seen[lf]) begin miss++; $display("FAIL random pass%0d addr[%0d]: got %0d", pass, n, addr_log[n]); end
          if (lf < L) seen[lf]++;
        end
      end
      for (int i = 0; i < L; i++) begin
        vec++; if (obs_cnt[i] !== NW) begin miss++; $display("FAIL random pass%0d leaf%0d count: got %0d want %0d", pass, i, obs_cnt[i], NW); end
        for (int k = 0; k < NW && k < obs_cnt[i]; k++) begin
          vec++; if (obs[i][k] !== ((k < LS) ? mem[i*LS+k] : {DW{1'b0}})) begin miss++; $display("FAIL random pass%0d leaf%0d word%0d: got %h want %h", pass, i, k, obs[i][k], (k < LS) ? mem[i*LS+k] : {DW{1'b0}}); end
        end
      end
      vec++; if (rd_viol !== 0 || wr_viol !== 0) begin miss++; $display("FAIL random pass%0d full-flag respect: rd=%0d wr=%0d want 0/0", pass, rd_viol, wr_viol); end
      $display("test_random pass %0d: %0d writes", pass, total_wr);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; fifo_full = '0;
    test_reset();
    test_nominal();
    test_completion();
    test_start_while_busy();
    test_stall();
    test_hold();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
